// File: rtl/pq_pkg.sv
// pq_pkg: shared types for the quickq priority queue and its request scheduler.
//   kv_t        key/value entry held by the queue (smaller key = higher priority)
//   KEYINF      sentinel entry returned when an op cannot be performed
//   PQ_CAPACITY number of entries the queue can hold
//   pq_op_t     scheduler command opcode
//   pq_rsp_t    scheduler response entry
//   pq_cmd_t    command FIFO entry
package pq_pkg;

  localparam int KEY_W       = 8;
  localparam int VAL_W       = 8;
  localparam int PQ_CAPACITY = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  localparam kv_t KEYINF = '{key: {KEY_W{1'b1}}, val: {VAL_W{1'b0}}};

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_REPL = 2'd3
  } pq_op_t;

  typedef struct packed {
    kv_t  kv;
    logic err;
  } pq_rsp_t;

  typedef struct packed {
    pq_op_t op;
    kv_t    kv;
  } pq_cmd_t;

endpackage

// File: rtl/pq_cmd_fifo.sv
// pq_cmd_fifo: synchronous FIFO with registered pointers.
//   clk      clock, rising edge
//   rst      synchronous active-low reset (pointers and storage cleared)
//   i_push   write i_data when not full
//   i_pop    drop head when not empty
//   o_data   head entry (reads as 0 after reset)
//   o_full   DEPTH entries held
//   o_empty  no entries held
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
module pq_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;

  assign o_empty = (r_wptr == r_rptr);
  // Full when the indices match but the wrap bits differ.
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + PW'(1);
      end
      if (i_pop && !o_empty) r_rptr <= r_rptr + PW'(1);
    end
  end

endmodule

// File: rtl/pq_req_sched.sv
// pq_req_sched: command scheduler in front of the quickq priority queue.
//   clk, rst                     clock; synchronous active-low reset
//   req_valid/req_ready/req_op/req_kv   command stream (NOP dropped at entry)
//   rsp_valid/rsp_ready/rsp_kv/rsp_err  response stream, command order
//   pq_enq, pq_deq, pq_kvi       single-cycle strobes and data to the queue
//   pq_kvo, pq_full, pq_empty, pq_busy  queue head and status
//   occ                          entries the scheduler believes the queue holds
// One op is in flight at a time: IDLE pops a command, ISSUE strobes the
// queue once it is free, WAIT collects the result, RESP pushes the response.
module pq_req_sched
  import pq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OCC_W      = $clog2(PQ_CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  pq_op_t           req_op,
  input  kv_t              req_kv,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output kv_t              rsp_kv,
  output logic             rsp_err,
  output logic             pq_enq,
  output logic             pq_deq,
  output kv_t              pq_kvi,
  input  kv_t              pq_kvo,
  input  logic             pq_full,
  input  logic             pq_empty,
  input  logic             pq_busy,
  output logic [OCC_W-1:0] occ
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  pq_op_t           r_op;
  kv_t              r_kv;
  kv_t              r_rsp_kv;
  logic             r_rsp_err;
  logic [OCC_W-1:0] r_occ;

  pq_cmd_t w_cmd_in, w_cmd_head;
  logic    w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
  pq_rsp_t w_rsp_in, w_rsp_head;
  logic    w_rsp_push, w_rsp_pop, w_rsp_full, w_rsp_empty;
  logic    w_enq, w_deq, w_err_set, w_capture;

  // Command side: ready depends only on registered FIFO pointers.
  assign req_ready  = !w_cmd_full;
  assign w_cmd_push = req_valid && !w_cmd_full && (req_op != OP_NOP);
  assign w_cmd_in   = '{op: req_op, kv: req_kv};

  pq_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(pq_cmd_t))) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_cmd_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_cmd_pop),
    .o_data  (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty)
  );

  // Response side: two slots, so one stalled response does not stop the
  // next op from completing.
  assign w_rsp_in  = '{kv: r_rsp_kv, err: r_rsp_err};
  assign rsp_valid = !w_rsp_empty;
  assign rsp_kv    = w_rsp_head.kv;
  assign rsp_err   = w_rsp_head.err;
  assign w_rsp_pop = rsp_valid && rsp_ready;

  pq_cmd_fifo #(.DEPTH(2), .W($bits(pq_rsp_t))) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rsp_push),
    .i_data  (w_rsp_in),
    .i_pop   (w_rsp_pop),
    .o_data  (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty)
  );

  assign pq_enq = w_enq;
  assign pq_deq = w_deq;
  assign pq_kvi = (r_op == OP_DEQ) ? '0 : r_kv;
  assign occ    = r_occ;

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_pop   = 1'b0;
    w_enq       = 1'b0;
    w_deq       = 1'b0;
    w_err_set   = 1'b0;
    w_capture   = 1'b0;
    w_rsp_push  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Nothing is in flight here, so a non-full response buffer means a
        // slot is guaranteed for whatever this command produces.
        if (!w_cmd_empty && !w_rsp_full) begin
          w_cmd_pop   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!pq_busy) begin
          case (r_op)
            OP_ENQ: begin
              if (pq_full) begin
                w_err_set   = 1'b1;
                w_state_nxt = S_RESP;
              end else begin
                w_enq       = 1'b1;
                w_state_nxt = S_WAIT;
              end
            end
            OP_DEQ: begin
              if (pq_empty) begin
                w_err_set   = 1'b1;
                w_state_nxt = S_RESP;
              end else begin
                w_deq       = 1'b1;
                w_state_nxt = S_WAIT;
              end
            end
            OP_REPL: begin
              // Replace on an empty queue degrades to a plain insert but
              // still reports that nothing was replaced out.
              w_enq = 1'b1;
              if (pq_empty) w_err_set = 1'b1;
              else          w_deq     = 1'b1;
              w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_WAIT: begin
        if (!pq_busy) begin
          if (r_op == OP_ENQ) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_capture   = !r_rsp_err;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        w_rsp_push  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op      <= OP_NOP;
      r_kv      <= '0;
      r_rsp_kv  <= '0;
      r_rsp_err <= 1'b0;
      r_occ     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_pop) begin
        r_op      <= w_cmd_head.op;
        r_kv      <= w_cmd_head.kv;
        r_rsp_kv  <= '0;
        r_rsp_err <= 1'b0;
      end
      if (w_err_set) begin
        r_rsp_err <= 1'b1;
        r_rsp_kv  <= KEYINF;
      end
      if (w_capture) r_rsp_kv <= pq_kvo;
      // A replace (both strobes) leaves the count unchanged.
      if (w_enq && !w_deq && (r_occ != OCC_W'(PQ_CAPACITY)))
        r_occ <= r_occ + OCC_W'(1);
      else if (w_deq && !w_enq && (r_occ != '0))
        r_occ <= r_occ - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_pq_req_sched.sv
// Directed bench for pq_req_sched with a small behavioural priority queue.
module tb_pq_req_sched;
  import pq_pkg::*;

  localparam int OCC_W = $clog2(PQ_CAPACITY + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  pq_op_t           req_op;
  kv_t              req_kv, rsp_kv, pq_kvi, pq_kvo;
  logic             pq_enq, pq_deq, pq_full, pq_empty, pq_busy;
  logic [OCC_W-1:0] occ;
  logic             tb_busy;

  always #5 clk = ~clk;

  pq_req_sched #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_kv(req_kv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_kv(rsp_kv), .rsp_err(rsp_err),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
    .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy), .occ(occ)
  );

  // Behavioural queue: sorted ascending by key; a dequeue presents the
  // removed entry on pq_kvo from the following cycle.
  kv_t [PQ_CAPACITY-1:0] mq;
  int                    mcnt = 0;
  kv_t                   kvo = '0;

  assign pq_full  = (mcnt == PQ_CAPACITY);
  assign pq_empty = (mcnt == 0);
  assign pq_kvo   = kvo;
  assign pq_busy  = tb_busy;

  always @(posedge clk) begin : qmodel
    kv_t [PQ_CAPACITY-1:0] t;
    int n, j;
    t = mq;
    n = mcnt;
    if (!rst) begin
      n = 0;
    end else begin
      if (pq_deq && n > 0) begin
        kvo <= t[0];
        for (int k = 0; k < PQ_CAPACITY - 1; k++) t[k] = t[k+1];
        n--;
      end
      if (pq_enq && n < PQ_CAPACITY) begin
        j = n;
        while (j > 0 && t[j-1].key > pq_kvi.key) begin
          t[j] = t[j-1];
          j--;
        end
        t[j] = pq_kvi;
        n++;
      end
    end
    mq   <= t;
    mcnt <= n;
  end

  // Observers, sampled mid-cycle.
  kv_t rk[$];
  bit  re[$];
  int  n_enq = 0, n_deq = 0, n_nrdy = 0;

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      rk.push_back(rsp_kv);
      re.push_back(rsp_err);
    end
    if (pq_enq)     n_enq++;
    if (pq_deq)     n_deq++;
    if (!req_ready) n_nrdy++;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input pq_op_t op, input logic [KEY_W-1:0] key, input logic [VAL_W-1:0] val);
    bit rdy;
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_kv    = '{key: key, val: val};
    do begin
      @(negedge clk);
      rdy = req_ready;
      tick();
      n++;
    end while (!rdy && n < 200);
    req_valid = 1'b0;
    req_op    = OP_NOP;
    if (!rdy) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rk.size() < target && n < 300) begin
      tick();
      n++;
    end
    chk("rsp_cnt", rk.size(), target);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, e0, d0, nr0;
    bit v;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_kv    = '0;
    rsp_ready = 1'b1;
    tb_busy   = 1'b0;
    rst       = 1'b0;

    // Reset values
    tickn(2);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_kv",    rsp_kv,    0);
    chk("rst_rsp_err",   rsp_err,   0);
    chk("rst_pq_enq",    pq_enq,    0);
    chk("rst_pq_deq",    pq_deq,    0);
    chk("rst_pq_kvi",    pq_kvi,    0);
    chk("rst_occ",       occ,       0);
    tick();
    rst = 1'b1;
    tickn(2);

    // DEQ on empty queue: error response, no strobe
    b = rk.size(); d0 = n_deq;
    send(OP_DEQ, 8'h00, 8'h00);
    wait_rsp(b + 1);
    chk("deq_empty_key", rk[b].key, 8'hFF);
    chk("deq_empty_err", re[b], 1);
    chk("deq_empty_nostrobe", n_deq - d0, 0);
    chk("deq_empty_occ", occ, 0);

    // Basic ordering
    send(OP_ENQ, 8'd5, 8'h50);
    send(OP_ENQ, 8'd2, 8'h20);
    send(OP_ENQ, 8'd9, 8'h90);
    tickn(15);
    chk("basic_occ3", occ, 3);
    b = rk.size();
    send(OP_DEQ, 8'h00, 8'h00);
    v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v |= rsp_valid;
      tick();
    end
    @(negedge clk);
    chk("lat_early", v, 0);
    chk("lat_valid", rsp_valid, 1);
    send(OP_DEQ, 8'h00, 8'h00);
    send(OP_DEQ, 8'h00, 8'h00);
    wait_rsp(b + 3);
    chk("basic_rsp0", rk[b],     16'h0220);
    chk("basic_rsp1", rk[b + 1], 16'h0550);
    chk("basic_rsp2", rk[b + 2], 16'h0990);
    chk("basic_err",  re[b] | re[b + 1] | re[b + 2], 0);
    tickn(3);
    chk("basic_occ0", occ, 0);

    // REPL on empty: insert only, error response
    b = rk.size(); e0 = n_enq; d0 = n_deq;
    send(OP_REPL, 8'd7, 8'h70);
    wait_rsp(b + 1);
    tickn(2);
    chk("repl_e_err",  re[b], 1);
    chk("repl_e_key",  rk[b].key, 8'hFF);
    chk("repl_e_enq",  n_enq - e0, 1);
    chk("repl_e_deq",  n_deq - d0, 0);
    chk("repl_e_occ",  occ, 1);

    // REPL on non-empty: old head out, count unchanged
    b = rk.size(); e0 = n_enq; d0 = n_deq;
    send(OP_REPL, 8'd3, 8'h30);
    wait_rsp(b + 1);
    tickn(2);
    chk("repl_kv",  rk[b], 16'h0770);
    chk("repl_err", re[b], 0);
    chk("repl_enq", n_enq - e0, 1);
    chk("repl_deq", n_deq - d0, 1);
    chk("repl_occ", occ, 1);
    b = rk.size();
    send(OP_DEQ, 8'h00, 8'h00);
    wait_rsp(b + 1);
    tickn(2);
    chk("repl_new_head", rk[b], 16'h0330);
    chk("repl_occ0", occ, 0);

    // Full queue
    for (int i = 0; i < PQ_CAPACITY; i++) send(OP_ENQ, 8'(8'h10 + i), 8'(i));
    tickn(30);
    chk("full_occ", occ, PQ_CAPACITY);
    b = rk.size(); e0 = n_enq;
    send(OP_ENQ, 8'h20, 8'h00);
    wait_rsp(b + 1);
    tickn(2);
    chk("full_err", re[b], 1);
    chk("full_key", rk[b].key, 8'hFF);
    chk("full_nostrobe", n_enq - e0, 0);
    chk("full_occ_sat", occ, PQ_CAPACITY);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("full_rst_occ", occ, 0);
    tick();

    // Backpressure on responses
    rsp_ready = 1'b0;
    b = rk.size(); d0 = n_deq; nr0 = n_nrdy;
    for (int i = 1; i <= 4; i++) send(OP_ENQ, 8'(i), 8'(8'h10 * i));
    for (int i = 0; i < 4; i++) send(OP_DEQ, 8'h00, 8'h00);
    tickn(30);
    chk("bp_deq_issued", n_deq - d0, 2);
    chk("bp_notready", (n_nrdy - nr0) > 0, 1);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_none_taken", rk.size(), b);
    rsp_ready = 1'b1;
    wait_rsp(b + 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_key", rk[b + i].key, i + 1);
      chk("bp_err", re[b + i], 0);
    end
    tickn(3);
    chk("bp_occ", occ, 0);

    // Busy held through ISSUE
    tb_busy = 1'b1;
    e0 = n_enq;
    send(OP_ENQ, 8'd6, 8'h66);
    tickn(6);
    tb_busy = 1'b0;
    chk("busy_no_early", n_enq - e0, 0);
    @(negedge clk);
    chk("busy_strobe", pq_enq, 1);
    chk("busy_kvi", pq_kvi, 16'h0666);
    tick();
    @(negedge clk);
    chk("busy_strobe_off", pq_enq, 0);
    tickn(4);
    chk("busy_one_wide", n_enq - e0, 1);
    chk("busy_occ", occ, 1);

    // Reset while an op sits in WAIT
    b = rk.size();
    send(OP_DEQ, 8'h00, 8'h00);
    tickn(2);
    tb_busy = 1'b1;
    send(OP_ENQ, 8'd8, 8'h88);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tb_busy = 1'b0;
    @(negedge clk);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_occ", occ, 0);
    chk("mid_rst_ready", req_ready, 1);
    e0 = n_enq;
    tickn(10);
    chk("mid_rst_fifo_empty", n_enq - e0, 0);
    chk("mid_rst_no_rsp", rk.size(), b);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
